// File: rtl/ijvm_reg_bank.sv
// ijvm_reg_bank: IJVM datapath register bank, C-bus write on posedge,
// B-bus read on negedge, built-in +/-1 step for pointer registers.
// Ports: clk, rst_n (async low); c_bus/c_write_enable write side;
// b_read_enable/b_sel/b_bus read side; step_en/step_sel/step_dir step;
// step_collision, sel_err status flags.
// Build option: IJVM_REG_BANK_TRISTATE_EN -> idle b_bus is Z, else 0.
module ijvm_reg_bank #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] c_bus,
  input  logic [NUM_REGS-1:0]   c_write_enable,
  input  logic                  b_read_enable,
  input  logic [SEL_WIDTH-1:0]  b_sel,
  output logic [WORD_WIDTH-1:0] b_bus,
  input  logic                  step_en,
  input  logic [SEL_WIDTH-1:0]  step_sel,
  input  logic                  step_dir,
  output logic                  step_collision,
  output logic                  sel_err
);

  localparam logic [SEL_WIDTH:0] NREG =
    (SEL_WIDTH+1)'(NUM_REGS);
  localparam logic [WORD_WIDTH-1:0] ONE =
    WORD_WIDTH'(1);

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  logic                  step_ok;
  logic                  read_ok;
  logic                  step_hit;
  logic                  step_coll;
  logic                  step_bad;
  logic                  read_bad;
  logic                  read_go;
  logic [WORD_WIDTH-1:0] step_cur;
  logic [WORD_WIDTH-1:0] step_val;
  logic                  err_p;
  logic                  err_n;
  logic [WORD_WIDTH-1:0] b_q;

  assign step_ok  = {1'b0, step_sel} < NREG;
  assign read_ok  = {1'b0, b_sel} < NREG;
  assign step_hit = step_en & step_ok;
  assign step_bad = step_en & ~step_ok;
  assign read_go  = b_read_enable & read_ok;
  assign read_bad = b_read_enable & ~read_ok;

  always_comb begin
    step_coll = 1'b0;
    step_cur  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (step_sel == SEL_WIDTH'(k)) begin
        step_cur  = regs[k];
        step_coll = step_hit & c_write_enable[k];
      end
    end
  end

  assign step_val = step_dir ? step_cur + ONE
                             : step_cur - ONE;

  // C write always wins over a step on the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++)
        regs[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (c_write_enable[k])
          regs[k] <= c_bus;
        else if (step_hit &&
                 step_sel == SEL_WIDTH'(k))
          regs[k] <= step_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_collision <= 1'b0;
    else        step_collision <= step_coll;
  end

  // sel_err is updated on both edges; the XOR pair makes the
  // output equal to whichever edge sampled last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_p <= 1'b0;
    else        err_p <= step_bad ^ err_n;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) err_n <= 1'b0;
    else        err_n <= read_bad ^ err_p;
  end

  assign sel_err = err_p ^ err_n;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)       b_q <= '0;
    else if (read_go) b_q <= regs[b_sel];
    else              b_q <= '0;
  end

`ifdef IJVM_REG_BANK_TRISTATE_EN
  logic b_drv;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) b_drv <= 1'b0;
    else        b_drv <= read_go;
  end

  assign b_bus = b_drv ? b_q : {WORD_WIDTH{1'bz}};
`else
  assign b_bus = b_q;
`endif

endmodule

// File: tb/tb_ijvm_reg_bank.sv
// tb_ijvm_reg_bank: random + directed check of ijvm_reg_bank,
// one 8-register and one 6-register instance against a model.
module tb_ijvm_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] c_bus;
  logic [7:0] we;
  logic       rd;
  logic [2:0] bsel;
  logic       sen;
  logic [2:0] ssel;
  logic       sdir;
  logic [7:0] b8;
  logic [7:0] b6;
  logic       coll8;
  logic       coll6;
  logic       err8;
  logic       err6;

`ifdef IJVM_REG_BANK_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  ijvm_reg_bank #(.WORD_WIDTH(8), .NUM_REGS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .c_bus(c_bus),
    .c_write_enable(we), .b_read_enable(rd),
    .b_sel(bsel), .b_bus(b8), .step_en(sen),
    .step_sel(ssel), .step_dir(sdir),
    .step_collision(coll8), .sel_err(err8)
  );

  ijvm_reg_bank #(.WORD_WIDTH(8), .NUM_REGS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .c_bus(c_bus),
    .c_write_enable(we[5:0]), .b_read_enable(rd),
    .b_sel(bsel), .b_bus(b6), .step_en(sen),
    .step_sel(ssel), .step_dir(sdir),
    .step_collision(coll6), .sel_err(err6)
  );

  int checks = 0;
  int errors = 0;

  int         m   [2][8];
  int         nr  [2] = '{8, 6};
  logic [7:0] eb  [2];
  logic       ec  [2];
  logic       ee  [2];

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) m[d][k] = 0;
      eb[d] = IDLE;
      ec[d] = 1'b0;
      ee[d] = 1'b0;
    end
  endtask

  task automatic model_pos();
    for (int d = 0; d < 2; d++) begin
      int  s;
      bit  inr;
      bit  col;
      s   = int'(ssel);
      inr = s < nr[d];
      col = sen && inr && we[s];
      for (int k = 0; k < nr[d]; k++)
        if (we[k]) m[d][k] = int'(c_bus);
      if (sen && inr && !col)
        m[d][s] = (m[d][s] + (sdir ? 1 : 255)) % 256;
      ec[d] = col;
      ee[d] = sen && !inr;
    end
  endtask

  task automatic model_neg();
    for (int d = 0; d < 2; d++) begin
      if (rd && int'(bsel) < nr[d]) begin
        eb[d] = 8'(m[d][bsel]);
        ee[d] = 1'b0;
      end else begin
        eb[d] = IDLE;
        ee[d] = rd;
      end
    end
  endtask

  task automatic idle_in();
    c_bus = 8'h00; we = 8'h00; rd = 1'b0;
    bsel = 3'd0; sen = 1'b0; ssel = 3'd0; sdir = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_pos();
    #1;
    chk("coll8", {7'd0, coll8}, {7'd0, ec[0]});
    chk("coll6", {7'd0, coll6}, {7'd0, ec[1]});
    chk("perr8", {7'd0, err8}, {7'd0, ee[0]});
    chk("perr6", {7'd0, err6}, {7'd0, ee[1]});
    @(negedge clk);
    model_neg();
    #1;
    chk("bus8", b8, eb[0]);
    chk("bus6", b6, eb[1]);
    chk("nerr8", {7'd0, err8}, {7'd0, ee[0]});
    chk("nerr6", {7'd0, err6}, {7'd0, ee[1]});
  endtask

  task automatic wr(input logic [7:0] mask,
                    input logic [7:0] val);
    idle_in(); we = mask; c_bus = val; cycle();
  endtask

  task automatic rdreg(input logic [2:0] r);
    idle_in(); rd = 1'b1; bsel = r; cycle();
  endtask

  task automatic stp(input logic [2:0] r,
                     input logic dir);
    idle_in(); sen = 1'b1; ssel = r; sdir = dir;
    rd = 1'b1; bsel = r; cycle();
  endtask

  initial begin
    idle_in();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_bus8", b8, IDLE);
    chk("rst_err8", {7'd0, err8}, 8'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    wr(8'hFF, 8'h5A);
    rdreg(3'd6);
    chk("pre_5a", b8, 8'h5A);

    // mid-cycle reset during the high phase
    idle_in(); rd = 1'b1; bsel = 3'd6;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_bus8", b8, IDLE);
    chk("mrst_bus6", b6, IDLE);
    chk("mrst_col", {7'd0, coll8}, 8'd0);
    chk("mrst_err", {7'd0, err8}, 8'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    rdreg(3'd6);
    chk("mrst_reg6", b8, 8'h00);

    idle_in(); we = 8'h08; c_bus = 8'hA5;
    rd = 1'b1; bsel = 3'd3; cycle();
    chk("rd_a5", b8, 8'hA5);
    idle_in(); cycle();
    chk("idle", b8, IDLE);

    wr(8'h81, 8'h3C);
    for (int k = 0; k < 8; k++) rdreg(3'(k));
    rdreg(3'd7);
    chk("mh_r7", b8, 8'h3C);
    rdreg(3'd1);
    chk("mh_r1", b8, 8'h00);

    wr(8'h10, 8'hFF);
    stp(3'd4, 1'b1);
    chk("wrap_up", b8, 8'h00);
    stp(3'd4, 1'b0);
    chk("wrap_dn", b8, 8'hFF);

    wr(8'h04, 8'h10);
    for (int i = 0; i < 3; i++) stp(3'd2, 1'b1);
    chk("inc3", b8, 8'h13);

    wr(8'h20, 8'h20);
    idle_in(); we = 8'h20; c_bus = 8'h77;
    sen = 1'b1; ssel = 3'd5; sdir = 1'b1;
    rd = 1'b1; bsel = 3'd5; cycle();
    chk("col_val", b8, 8'h77);
    chk("col_flag", {7'd0, coll8}, 8'd1);
    rdreg(3'd5);
    chk("col_clr", {7'd0, coll8}, 8'd0);
    chk("col_keep", b8, 8'h77);

    rdreg(3'd7);
    chk("oor_bus6", b6, IDLE);
    chk("oor_err6", {7'd0, err6}, 8'd1);
    idle_in(); sen = 1'b1; ssel = 3'd6; sdir = 1'b1;
    cycle();
    rdreg(3'd0);
    chk("oor_clr6", {7'd0, err6}, 8'd0);

    for (int i = 0; i < 400; i++) begin
      idle_in();
      c_bus = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        we = 8'($urandom) & 8'($urandom);
      sen  = 1'($urandom);
      ssel = 3'($urandom);
      sdir = 1'($urandom);
      rd   = ($urandom_range(0, 3) != 0);
      bsel = 3'($urandom);
      if ($urandom_range(0, 4) == 0)
        we[ssel] = 1'b1;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
